hazard_ctrl_p: RTL and testbench
================================

HAZARD_CTRL_P -- requirements
Module: hazard_ctrl_p

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AW, 5: register-address width.
- LOAD_STALL, 2: total stall cycles per load-use hazard, legal range 1..7.
- MDU_LAT, 4: cycles a multi-cycle mul/div op occupies Execute, legal range 1..15.
- CNT_W, 32: stall performance-counter width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enables for Execute, Memory, Writeback.
- ResultSrcE  in  1  load instruction in Execute.
- MduE  in  1  multi-cycle op in Execute.
- PcSrcE  in  1  branch/jump taken in Execute.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  AW each  source and destination register addresses per stage.
- stallF, stallD, stallE  out  1 each  hold Fetch, Decode, Execute.
- FlushD, FlushE, FlushM  out  1 each  bubble into Decode, Execute, Memory.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 Writeback, 10 Memory.
- mdu_busy  out  1  a multi-cycle op is holding Execute.
- stall_cycles  out  CNT_W  saturating count of cycles with stallF=1.

Function
REQ-003 ForwardAE SHALL be 10 if RegWriteM & Rs1E!=0 & Rs1E==RdM; otherwise 01 if RegWriteW & Rs1E!=0 & Rs1E==RdW; otherwise 00.
REQ-004 ForwardBE SHALL follow the REQ-003 rule using Rs2E.
REQ-005 The block SHALL define lwhit = ResultSrcE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
REQ-006 The FSM SHALL have three states, IDLE, LOAD and MDU, plus one 3-bit load counter and one 4-bit MDU counter.
REQ-007 Event priority in IDLE SHALL be PcSrcE, then lwhit, then MduE. A lower-priority event SHALL be ignored in any cycle where a higher-priority event is present.
REQ-008 IDLE with PcSrcE=1: FlushD=1, FlushE=1, no stall, state stays IDLE.
REQ-009 IDLE with lwhit=1: stallF=stallD=1 and FlushE=1 this cycle. If LOAD_STALL>1, the FSM SHALL go to LOAD with the load counter set to LOAD_STALL-2; otherwise it stays IDLE.
REQ-010 LOAD: stallF=stallD=FlushE=1 every cycle. The FSM SHALL go to IDLE when the load counter equals 0, otherwise decrement the counter. Total stall length SHALL be exactly LOAD_STALL cycles.
REQ-011 IDLE with MduE=1 and MDU_LAT>1: stallF=stallD=stallE=FlushM=1 and mdu_busy=1; the FSM SHALL go to MDU with the MDU counter set to MDU_LAT-2.
REQ-012 MDU with counter !=0: stallF=stallD=stallE=FlushM=mdu_busy=1, and the counter SHALL decrement.
REQ-013 MDU with counter =0 (release cycle): all stalls and mdu_busy SHALL be 0, and the FSM SHALL go to IDLE. The op therefore spends exactly MDU_LAT cycles in Execute.
REQ-014 MDU_LAT=1 SHALL produce no stall and no state change.
REQ-015 In LOAD and MDU states, lwhit, MduE and PcSrcE SHALL NOT alter the state or counters.
REQ-016 In LOAD and MDU states, PcSrcE=1 SHALL still drive FlushD=1, but FlushE stays as defined for the state.
REQ-017 Forwarding (REQ-003/004) SHALL be active in all states.
REQ-018 All stall/flush/busy outputs SHALL be combinational from state, counters and inputs, with no added latency.
REQ-019 stall_cycles SHALL increment on each clock edge where stallF=1 and SHALL hold at all-ones, never wrapping.
REQ-020 Any output not asserted by REQ-008..REQ-014 SHALL be 0.

Reset
REQ-021 On a clock edge with reset=0: state=IDLE, both FSM counters=0, stall_cycles=0.
REQ-022 While reset=0, outputs SHALL be forced to: stallF/D/E=0, FlushM=0, mdu_busy=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00.
REQ-023 Reset asserted mid-LOAD or mid-MDU SHALL abort the sequence. The first cycle after release SHALL be IDLE, with no residual stall.

Verification
REQ-024 Forwarding:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10.
- Same, with Rs1E=0 -> ForwardAE=00.
- Rs2E=7, RdW=7, RegWriteW=1, RegWriteM=0 -> ForwardBE=01.
REQ-025 LOAD_STALL=2: ResultSrcE=1, RdE=3, Rs2D=3 for one cycle -> stallF=stallD=FlushE=1 for exactly 2 cycles, then 0; stall_cycles=2.
REQ-026 LOAD_STALL=3 and LOAD_STALL=1 variants -> stall lasts 3 and 1 cycles respectively. RdE=0 with Rs1D=0 -> no stall.
REQ-027 MDU_LAT=4: MduE=1 held -> stallE=mdu_busy=FlushM=1 for 3 cycles, release on the 4th, then IDLE. MDU_LAT=1 -> never stalls.
REQ-028 Simultaneous events:
- PcSrcE=1 with lwhit=1 in IDLE -> FlushD=FlushE=1, no stall, state IDLE.
- ResultSrcE=1 and MduE=1 with lwhit -> LOAD sequence only.
REQ-029 Reset and saturation:
- reset=0 on the 2nd MDU stall cycle -> next post-reset cycle has stallE=0 and stall_cycles=0.
- CNT_W=4 with 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/hazard_ctrl_p_if.sv
// hazard_ctrl_p_if: pipeline-to-hazard-unit signal bundle
interface hazard_ctrl_p_if #(
  parameter int AW = 5,
  parameter int CNT_W = 32
);
  logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MduE, PcSrcE;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic stallF, stallD, stallE, FlushD, FlushE, FlushM, mdu_busy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MduE, PcSrcE,
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input stallF, stallD, stallE, FlushD, FlushE, FlushM, mdu_busy,
    input ForwardAE, ForwardBE, stall_cycles
  );
  modport slave (
    input RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MduE, PcSrcE,
    input Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output stallF, stallD, stallE, FlushD, FlushE, FlushM, mdu_busy,
    output ForwardAE, ForwardBE, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: forwarding, load-use and multi-cycle-op stall/flush control
module hazard_ctrl_p #(
  parameter int AW = 5,
  parameter int LOAD_STALL = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  hazard_ctrl_p_if.slave hz
);
  typedef enum logic [1:0] {IDLE, LOAD, MDU} state_t;
  localparam logic [AW-1:0] R0 = '0;
  state_t state_q, state_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lwhit, ev_pc, ev_ld, ev_md, hold_ld, hold_md;
  logic unused_ok;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs, input logic [AW-1:0] rdm,
                                     input logic [AW-1:0] rdw, input logic wm, input logic ww);
    return (wm && rs != R0 && rs == rdm) ? 2'b10 : (ww && rs != R0 && rs == rdw) ? 2'b01 : 2'b00;
  endfunction

  assign unused_ok = hz.RegWriteE;
  assign lwhit = hz.ResultSrcE && hz.RdE != R0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
  assign ev_pc = state_q == IDLE && hz.PcSrcE;
  assign ev_ld = state_q == IDLE && !hz.PcSrcE && lwhit;
  assign ev_md = state_q == IDLE && !hz.PcSrcE && !lwhit && hz.MduE && MDU_LAT > 1;
  assign hold_ld = state_q == LOAD;
  assign hold_md = state_q == MDU && mcnt_q != 4'd0;
  assign hz.stall_cycles = cnt_q;

  // state, sequence counters and saturating stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lcnt_q <= '0;
      mcnt_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q <= lcnt_d;
      mcnt_q <= mcnt_d;
      cnt_q <= cnt_d;
    end
  end

  // next state: IDLE arbitrates events, LOAD/MDU count down and ignore new events
  always_comb begin
    state_d = state_q;
    lcnt_d = lcnt_q;
    mcnt_d = mcnt_q;
    if (ev_ld && LOAD_STALL > 1) begin
      state_d = LOAD;
      lcnt_d = 3'(LOAD_STALL - 2);
    end else if (ev_md) begin
      state_d = MDU;
      mcnt_d = 4'(MDU_LAT - 2);
    end else if (hold_ld) begin
      state_d = (lcnt_q == 3'd0) ? IDLE : LOAD;
      lcnt_d = lcnt_q - 3'(lcnt_q != 3'd0);
    end else if (state_q == MDU) begin
      state_d = (mcnt_q == 4'd0) ? IDLE : MDU;
      mcnt_d = mcnt_q - 4'(mcnt_q != 4'd0);
    end
    cnt_d = (hz.stallF && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // outputs: combinational from state and inputs, forced safe while in reset
  always_comb begin
    hz.stallF = reset && (ev_ld || hold_ld || ev_md || hold_md);
    hz.stallD = hz.stallF;
    hz.stallE = reset && (ev_md || hold_md);
    hz.FlushM = hz.stallE;
    hz.mdu_busy = hz.stallE;
    hz.FlushD = !reset || hz.PcSrcE;
    hz.FlushE = !reset || ev_pc || ev_ld || hold_ld;
    hz.ForwardAE = reset ? fwd(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : 2'b00;
    hz.ForwardBE = reset ? fwd(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : 2'b00;
  end
endmodule

// File: tb/tb_hazard_ctrl_p.sv
// tb_hazard_ctrl_p: directed vector table plus multi-cycle sequences across parameter variants
module tb_hazard_ctrl_p;
  typedef struct packed {logic [5:0] f; logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;} in_t;
  typedef struct packed {logic [6:0] f; logic [1:0] fa, fb;} out_t;
  typedef struct {logic r; in_t i; out_t o; int cnt;} vec_t;

  localparam bit [5:0] RWM = 6'b010000, RWW = 6'b001000, RSE = 6'b000100, MD_I = 6'b000010, PC = 6'b000001;
  localparam bit [6:0] LD = 7'b1100100, MD = 7'b1110011, FD = 7'b0001000, FP = 7'b0001100, RO = 7'b0001100;

  logic clk = 1'b0;
  logic rst_n;
  in_t vin;
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  int na, nb, nc;
  in_t zi, hit;
  out_t oa;

  hazard_ctrl_p_if #(.AW(5), .CNT_W(32)) ia();
  hazard_ctrl_p_if #(.AW(5), .CNT_W(4)) ib();
  hazard_ctrl_p_if #(.AW(5), .CNT_W(32)) ic();

  hazard_ctrl_p #(.AW(5), .LOAD_STALL(2), .MDU_LAT(4), .CNT_W(32)) ua (.clk(clk), .reset(rst_n), .hz(ia));
  hazard_ctrl_p #(.AW(5), .LOAD_STALL(3), .MDU_LAT(1), .CNT_W(4)) ub (.clk(clk), .reset(rst_n), .hz(ib));
  hazard_ctrl_p #(.AW(5), .LOAD_STALL(1), .MDU_LAT(4), .CNT_W(32)) uc (.clk(clk), .reset(rst_n), .hz(ic));

  assign {ia.RegWriteE, ia.RegWriteM, ia.RegWriteW, ia.ResultSrcE, ia.MduE, ia.PcSrcE,
          ia.Rs1D, ia.Rs2D, ia.Rs1E, ia.Rs2E, ia.RdE, ia.RdM, ia.RdW} = vin;
  assign {ib.RegWriteE, ib.RegWriteM, ib.RegWriteW, ib.ResultSrcE, ib.MduE, ib.PcSrcE,
          ib.Rs1D, ib.Rs2D, ib.Rs1E, ib.Rs2E, ib.RdE, ib.RdM, ib.RdW} = vin;
  assign {ic.RegWriteE, ic.RegWriteM, ic.RegWriteW, ic.ResultSrcE, ic.MduE, ic.PcSrcE,
          ic.Rs1D, ic.Rs2D, ic.Rs1E, ic.Rs2E, ic.RdE, ic.RdM, ic.RdW} = vin;
  assign oa = {ia.stallF, ia.stallD, ia.stallE, ia.FlushD, ia.FlushE, ia.FlushM, ia.mdu_busy,
               ia.ForwardAE, ia.ForwardBE};

  always #5 clk = ~clk;

  function automatic in_t mk_in(bit [5:0] f, int a, int b, int c, int d, int e, int m, int w);
    return {f, 5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(m), 5'(w)};
  endfunction

  function automatic void add(bit r, bit [5:0] f, int a, int b, int c, int d, int e, int m, int w,
                              bit [6:0] of, bit [1:0] fa, bit [1:0] fb, int cnt);
    vec_t v;
    v.r = r;
    v.i = mk_in(f, a, b, c, d, e, m, w);
    v.o = {of, fa, fb};
    v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input in_t v);
    @(negedge clk);
    rst_n = r;
    vin = v;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    vin = '0;
    zi = '0;
    hit = mk_in(RSE, 0, 3, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, RO, 0, 0, 0);
    add(1, RWM | RWW, 0, 0, 5, 0, 0, 5, 5, 0, 2, 0, 0);
    add(1, RWM | RWW, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0);
    add(1, RWW, 0, 0, 0, 7, 0, 0, 7, 0, 0, 1, 0);
    add(1, RWM | RWW, 0, 0, 9, 4, 0, 4, 9, 0, 1, 2, 0);
    add(1, 0, 0, 0, 3, 0, 0, 3, 0, 0, 0, 0, 0);
    add(1, RSE, 0, 3, 0, 0, 3, 0, 0, LD, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, LD, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, RSE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, PC | RSE, 3, 0, 0, 0, 3, 0, 0, FP, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, RSE | MD_I, 4, 0, 0, 0, 4, 0, 0, LD, 0, 0, 2);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, LD, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(1, RSE, 2, 0, 0, 0, 2, 0, 0, LD, 0, 0, 4);
    add(1, PC, 0, 0, 0, 0, 0, 0, 0, LD | FD, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, MD, 0, 0, 6);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, MD, 0, 0, 7);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, MD, 0, 0, 8);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, MD, 0, 0, 9);
    add(1, PC | RSE | RWM, 3, 0, 8, 0, 3, 8, 0, MD | FD, 2, 0, 10);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, MD, 0, 0, 11);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
    add(1, MD_I, 0, 0, 0, 0, 0, 0, 0, MD, 0, 0, 12);
    add(0, MD_I, 0, 0, 0, 0, 0, 0, 0, RO, 0, 0, 13);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, RSE, 0, 3, 0, 0, 3, 0, 0, LD, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, RO, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, zi);
    step(0, zi);
    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].i);
      chk($sformatf("vec%0d_out", n), 64'(oa), 64'(tbl[n].o));
      chk($sformatf("vec%0d_cnt", n), 64'(ia.stall_cycles), 64'(tbl[n].cnt));
    end
    step(0, zi);
    na = 0; nb = 0; nc = 0;
    for (int k = 0; k < 6; k++) begin
      step(1, k == 0 ? hit : zi);
      na += int'(ia.stallF && ia.FlushE);
      nb += int'(ib.stallF && ib.FlushE);
      nc += int'(ic.stallF && ic.FlushE);
    end
    step(1, zi);
    chk("load_len_ls2", 64'(na), 64'd2);
    chk("load_len_ls3", 64'(nb), 64'd3);
    chk("load_len_ls1", 64'(nc), 64'd1);
    chk("load_cnt_ls3", 64'(ib.stall_cycles), 64'd3);
    chk("load_cnt_ls1", 64'(ic.stall_cycles), 64'd1);
    step(0, zi);
    nb = 0; nc = 0;
    for (int k = 0; k < 3; k++) begin
      step(1, mk_in(MD_I, 0, 0, 0, 0, 0, 0, 0));
      nb += int'(ib.stallF || ib.stallE || ib.mdu_busy);
      nc += int'(ic.stallE && ic.mdu_busy && ic.FlushM);
    end
    step(1, zi);
    chk("mdu_lat1_stalls", 64'(nb), 64'd0);
    chk("mdu_lat4_busy", 64'(nc), 64'd3);
    chk("mdu_release_busy", 64'(ic.mdu_busy), 64'd0);
    chk("mdu_lat1_cnt", 64'(ib.stall_cycles), 64'd0);
    step(0, zi);
    for (int k = 0; k < 20; k++) step(1, hit);
    step(1, zi);
    chk("sat_cnt4", 64'(ib.stall_cycles), 64'd15);
    chk("sat_cnt32_ls2", 64'(ia.stall_cycles), 64'd20);
    chk("sat_cnt32_ls1", 64'(ic.stall_cycles), 64'd20);
    step(1, hit);
    step(1, zi);
    chk("sat_hold", 64'(ib.stall_cycles), 64'd15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
